// File: rtl/sweep_pkg.sv
// Shared types and helpers for the sweep mask controller.
package sweep_pkg;

  localparam int DUTY_FRAC_W_DEF = 16;
  localparam int MIN_DIV_DEF     = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // One saturated step from cur toward tgt; never overshoots, never wraps.
  function automatic logic [31:0] step_toward(input logic [31:0] cur,
                                              input logic [31:0] tgt,
                                              input logic [31:0] stp);
    logic [32:0] sum;
    logic        dir;
    dir = (tgt >= cur) ? DIR_UP : DIR_DOWN;
    sum = {1'b0, cur} + {1'b0, stp};
    if (dir == DIR_UP)
      step_toward = (sum > {1'b0, tgt}) ? tgt : sum[31:0];
    else
      step_toward = ((cur - tgt) <= stp) ? tgt : (cur - stp);
  endfunction

endpackage

// File: rtl/sweep_duty_mul.sv
// Two-stage duty multiplier: (div * frac) >> FRAC_W, with a minimum of 1
// whenever the fraction is non-zero. Result holds until the next launch.
module sweep_duty_mul #(
  parameter int FRAC_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_vld,
  input  logic [31:0]       i_div,
  input  logic [FRAC_W-1:0] i_frac,
  output logic              o_vld,
  output logic [31:0]       o_duty
);
  localparam int PW = 32 + FRAC_W;

  logic [PW-1:0] r_prod;
  logic          r_frac_nz;
  logic [2:1]    r_vld_pipe;
  logic [31:0]   r_duty;
  logic [31:0]   w_shift;

  assign w_shift = r_prod[PW-1:FRAC_W];
  assign o_vld   = r_vld_pipe[2];
  assign o_duty  = r_duty;

  // Stage 1: full-width product, captured only on launch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prod    <= '0;
      r_frac_nz <= 1'b0;
    end else if (i_vld) begin
      r_prod    <= PW'(i_div) * PW'(i_frac);
      r_frac_nz <= |i_frac;
    end
  end

  // Valid shift register tracking the launch through both stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_vld_pipe <= '0;
    else        r_vld_pipe <= {r_vld_pipe[1], i_vld};
  end

  // Stage 2: shift and min-1 clamp so a tiny non-zero fraction still pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             r_duty <= '0;
    else if (r_vld_pipe[1]) r_duty <= (r_frac_nz && (w_shift == 32'd0)) ? 32'd1 : w_shift;
  end

endmodule

// File: rtl/sweep_mask_ctrl.sv
// Sweep mask controller: steps the mask period from start to stop, holding
// each value for 'dwell' periods, with duty tracking the period.
// Optional build macro SWEEP_BOUNCE_EN: in loop mode, reverse at each
// endpoint (triangle sweep) instead of reloading the start value.
module sweep_mask_ctrl
  import sweep_pkg::*;
#(
  parameter int DUTY_FRAC_W = DUTY_FRAC_W_DEF,
  parameter int MIN_DIV     = MIN_DIV_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [31:0]            start_div,
  input  logic [31:0]            stop_div,
  input  logic [31:0]            step,
  input  logic [15:0]            dwell,
  input  logic [DUTY_FRAC_W-1:0] duty_frac,
  input  logic                   loop_mode,
  output logic [31:0]            divider,
  output logic [31:0]            duty,
  output logic                   period_tick,
  output logic                   sweep_done,
  output logic                   cfg_err
);
  localparam logic [31:0] MIN_DIV_L = 32'(MIN_DIV);

  state_e                 r_state;
  logic                   r_en_d, r_loop, r_cfg_err;
  logic [31:0]            r_from, r_to, r_step, r_div, r_duty, r_cnt;
  logic [15:0]            r_dwell, r_dwell_cnt;
  logic [DUTY_FRAC_W-1:0] r_frac;

  logic                   w_rise, w_cfg_bad, w_tick, w_dwell_last, w_at_end;
  logic [31:0]            w_start_c, w_stop_c, w_next_div;
  logic [15:0]            w_dwell_eff;
  logic                   w_mul_go, w_mul_vld;
  logic [31:0]            w_mul_a, w_mul_duty;
  logic [DUTY_FRAC_W-1:0] w_mul_frac;

  assign w_rise       = enable & ~r_en_d;
  assign w_cfg_bad    = (start_div == 32'd0) || (stop_div == 32'd0);
  assign w_start_c    = (start_div < MIN_DIV_L) ? MIN_DIV_L : start_div;
  assign w_stop_c     = (stop_div  < MIN_DIV_L) ? MIN_DIV_L : stop_div;
  assign w_tick       = (r_state == ST_RUN) && (r_cnt == r_div - 32'd1);
  assign w_dwell_eff  = (r_dwell == 16'd0) ? 16'd1 : r_dwell;
  assign w_dwell_last = (r_dwell_cnt == w_dwell_eff - 16'd1);
  // Saturation lands exactly on the target, so equality marks the endpoint.
  assign w_at_end     = (r_step != 32'd0) && (r_div == r_to);

  // Next divider: saturated step, or wrap/reverse at the endpoint.
  always_comb begin
    w_next_div = r_div;
    if (r_step != 32'd0) begin
      if (!w_at_end) w_next_div = step_toward(r_div, r_to, r_step);
      else begin
`ifdef SWEEP_BOUNCE_EN
        w_next_div = step_toward(r_div, r_from, r_step);
`else
        w_next_div = r_from;
`endif
      end
    end
  end

  // The first duty is launched from the raw inputs on the enable edge; in RUN
  // the next value's duty is launched at count 0, settling well before the
  // swap since every period is at least MIN_DIV cycles.
  assign w_mul_go   = ((r_state == ST_IDLE) && w_rise && !w_cfg_bad) ||
                      ((r_state == ST_RUN) && enable && (r_cnt == 32'd0));
  assign w_mul_a    = (r_state == ST_IDLE) ? w_start_c : w_next_div;
  assign w_mul_frac = (r_state == ST_IDLE) ? duty_frac : r_frac;

  sweep_duty_mul #(.FRAC_W(DUTY_FRAC_W)) u_mul (
    .clk    (clk),
    .rst_n  (reset),
    .i_vld  (w_mul_go),
    .i_div  (w_mul_a),
    .i_frac (w_mul_frac),
    .o_vld  (w_mul_vld),
    .o_duty (w_mul_duty)
  );

  // Main FSM with period and dwell counters; enable low always wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;  r_en_d <= 1'b0;  r_cfg_err <= 1'b0;  r_loop <= 1'b0;
      r_from <= '0;  r_to <= '0;  r_step <= '0;  r_dwell <= '0;  r_frac <= '0;
      r_div <= '0;  r_duty <= '0;  r_cnt <= '0;  r_dwell_cnt <= '0;
    end else begin
      r_en_d <= enable;
      if (!enable) begin
        r_state <= ST_IDLE;  r_cfg_err <= 1'b0;
        r_div <= '0;  r_duty <= '0;  r_cnt <= '0;  r_dwell_cnt <= '0;
      end else begin
        case (r_state)
          ST_IDLE: if (w_rise) begin
            if (w_cfg_bad) r_cfg_err <= 1'b1;
            else begin
              r_from <= w_start_c;  r_to <= w_stop_c;  r_step <= step;
              r_dwell <= dwell;  r_frac <= duty_frac;  r_loop <= loop_mode;
              r_state <= ST_LOAD;
            end
          end
          ST_LOAD: if (w_mul_vld) begin
            r_state <= ST_RUN;  r_div <= r_from;  r_duty <= w_mul_duty;
            r_cnt <= '0;  r_dwell_cnt <= '0;
          end
          ST_RUN: if (w_tick) begin
            r_cnt <= '0;
            if (w_dwell_last) begin
              r_dwell_cnt <= '0;
              if (w_at_end && !r_loop) r_state <= ST_DONE;
              else begin
                r_div  <= w_next_div;
                r_duty <= w_mul_duty;
`ifdef SWEEP_BOUNCE_EN
                if (w_at_end) begin
                  r_from <= r_to;
                  r_to   <= r_from;
                end
`endif
              end
            end else r_dwell_cnt <= r_dwell_cnt + 16'd1;
          end else r_cnt <= r_cnt + 32'd1;
          ST_DONE: ;
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign divider     = r_div;
  assign duty        = r_duty;
  assign period_tick = w_tick;
  assign sweep_done  = (r_state == ST_DONE);
  assign cfg_err     = r_cfg_err;

endmodule

// File: tb/tb_sweep_mask_ctrl.sv
// Directed bench for sweep_mask_ctrl (default build; bounce expectations
// selected by SWEEP_BOUNCE_EN).
module tb_sweep_mask_ctrl;
  logic        clk = 1'b0;
  logic        reset, enable, loop_mode;
  logic [31:0] start_div, stop_div, step;
  logic [15:0] dwell, duty_frac;
  logic [31:0] divider, duty;
  logic        period_tick, sweep_done, cfg_err;

  int checks = 0;
  int errors = 0;
  int got_div[16], got_duty[16], got_len[16];
  int got_n;

  always #5 clk = ~clk;

  sweep_mask_ctrl dut (
    .clk(clk), .reset(reset), .enable(enable), .start_div(start_div),
    .stop_div(stop_div), .step(step), .dwell(dwell), .duty_frac(duty_frac),
    .loop_mode(loop_mode), .divider(divider), .duty(duty),
    .period_tick(period_tick), .sweep_done(sweep_done), .cfg_err(cfg_err)
  );

  // Drop enable for a cycle, program config, raise enable on a negedge.
  task automatic start_sweep(input logic [31:0] s, input logic [31:0] p,
                             input logic [31:0] st, input logic [15:0] dw,
                             input logic [15:0] fr, input logic lp);
    @(negedge clk); enable = 1'b0;
    @(negedge clk);
    start_div = s; stop_div = p; step = st; dwell = dw; duty_frac = fr; loop_mode = lp;
    enable = 1'b1;
  endtask

  // Record divider/duty/spacing at each tick, bounded by a cycle budget.
  task automatic collect(input int n, input int budget);
    int len;
    len = 0;
    got_n = 0;
    for (int c = 0; c < budget && got_n < n; c++) begin
      @(negedge clk);
      len++;
      if (period_tick === 1'b1) begin
        got_div[got_n] = int'(divider); got_duty[got_n] = int'(duty);
        got_len[got_n] = len; got_n++; len = 0;
      end
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++; if (divider !== 32'd0) begin errors++; $display("FAIL reset_div got %0d want 0", divider); end
    checks++; if (duty !== 32'd0) begin errors++; $display("FAIL reset_duty got %0d want 0", duty); end
    checks++; if ({period_tick, sweep_done, cfg_err} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got %b want 000", {period_tick, sweep_done, cfg_err}); end
    reset = 1'b1;
  endtask

  task automatic test_up;
    int ed[6] = '{10, 10, 15, 15, 20, 20};
    int eu[6] = '{5, 5, 7, 7, 10, 10};
    int ticks;
    start_sweep(10, 20, 5, 2, 16'h8000, 1'b0);
    repeat (2) @(negedge clk);
    checks++; if (divider !== 32'd0) begin errors++; $display("FAIL up_load_div got %0d want 0", divider); end
    @(negedge clk);
    checks++; if (divider !== 32'd10 || duty !== 32'd5) begin
      errors++; $display("FAIL up_run_entry got %0d/%0d want 10/5", divider, duty); end
    collect(6, 300);
    checks++; if (got_n !== 6) begin errors++; $display("FAIL up_count got %0d want 6", got_n); end
    for (int i = 0; i < got_n; i++) begin
      checks++; if (got_div[i] !== ed[i] || got_duty[i] !== eu[i]) begin
        errors++; $display("FAIL up_val[%0d] got %0d/%0d want %0d/%0d", i, got_div[i], got_duty[i], ed[i], eu[i]); end
      if (i > 0) begin
        checks++; if (got_len[i] !== ed[i]) begin
          errors++; $display("FAIL up_len[%0d] got %0d want %0d", i, got_len[i], ed[i]); end
      end
    end
    @(negedge clk);
    checks++; if (sweep_done !== 1'b1 || divider !== 32'd20 || duty !== 32'd10) begin
      errors++; $display("FAIL up_done got %b %0d/%0d want 1 20/10", sweep_done, divider, duty); end
    ticks = 0;
    repeat (40) begin @(negedge clk); if (period_tick === 1'b1) ticks++; end
    checks++; if (ticks !== 0) begin errors++; $display("FAIL up_done_ticks got %0d want 0", ticks); end
  endtask

  task automatic test_saturation;
    int ed[3] = '{10, 15, 18};
    int eu[3] = '{2, 3, 4};
    start_sweep(10, 18, 5, 1, 16'h4000, 1'b0);
    collect(3, 200);
    checks++; if (got_n !== 3) begin errors++; $display("FAIL sat_count got %0d want 3", got_n); end
    for (int i = 0; i < got_n; i++) begin
      checks++; if (got_div[i] !== ed[i] || got_duty[i] !== eu[i]) begin
        errors++; $display("FAIL sat_val[%0d] got %0d/%0d want %0d/%0d", i, got_div[i], got_duty[i], ed[i], eu[i]); end
    end
    @(negedge clk);
    checks++; if (sweep_done !== 1'b1 || divider !== 32'd18) begin
      errors++; $display("FAIL sat_done got %b %0d want 1 18", sweep_done, divider); end
  endtask

  task automatic test_down_loop;
    int ed[6] = '{20, 10, 20, 10, 20, 10};
    start_sweep(20, 10, 10, 1, 16'h8000, 1'b1);
    collect(6, 300);
    checks++; if (got_n !== 6) begin errors++; $display("FAIL down_count got %0d want 6", got_n); end
    for (int i = 0; i < got_n; i++) begin
      checks++; if (got_div[i] !== ed[i] || got_duty[i] !== ed[i] / 2) begin
        errors++; $display("FAIL down_val[%0d] got %0d/%0d want %0d/%0d", i, got_div[i], got_duty[i], ed[i], ed[i] / 2); end
      if (i > 0) begin
        checks++; if (got_len[i] !== ed[i]) begin
          errors++; $display("FAIL down_len[%0d] got %0d want %0d", i, got_len[i], ed[i]); end
      end
    end
    checks++; if (sweep_done !== 1'b0) begin errors++; $display("FAIL down_not_done got %b want 0", sweep_done); end
  endtask

  task automatic test_loop_wrap;
`ifdef SWEEP_BOUNCE_EN
    int ed[6] = '{10, 20, 30, 20, 10, 20};
`else
    int ed[6] = '{10, 20, 30, 10, 20, 30};
`endif
    start_sweep(10, 30, 10, 1, 16'h8000, 1'b1);
    collect(6, 400);
    checks++; if (got_n !== 6) begin errors++; $display("FAIL wrap_count got %0d want 6", got_n); end
    for (int i = 0; i < got_n; i++) begin
      checks++; if (got_div[i] !== ed[i]) begin
        errors++; $display("FAIL wrap_val[%0d] got %0d want %0d", i, got_div[i], ed[i]); end
    end
  endtask

  task automatic test_degenerate;
    start_sweep(0, 20, 5, 1, 16'h8000, 1'b0);
    repeat (4) @(negedge clk);
    checks++; if (cfg_err !== 1'b1 || divider !== 32'd0) begin
      errors++; $display("FAIL cfg_start0 got %b %0d want 1 0", cfg_err, divider); end
    enable = 1'b0;
    @(negedge clk);
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL cfg_clear got %b want 0", cfg_err); end
    start_sweep(10, 0, 5, 1, 16'h8000, 1'b0);
    repeat (3) @(negedge clk);
    checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_stop0 got %b want 1", cfg_err); end
    start_sweep(2, 2, 1, 1, 16'h0001, 1'b0);
    collect(1, 50);
    checks++; if (got_n !== 1 || got_div[0] !== 4 || got_duty[0] !== 1) begin
      errors++; $display("FAIL clamp got n=%0d %0d/%0d want n=1 4/1", got_n, got_div[0], got_duty[0]); end
    @(negedge clk);
    checks++; if (sweep_done !== 1'b1 || divider !== 32'd4) begin
      errors++; $display("FAIL clamp_done got %b %0d want 1 4", sweep_done, divider); end
  endtask

  task automatic test_step0;
    start_sweep(6, 12, 0, 1, 16'h0000, 1'b0);
    collect(5, 200);
    checks++; if (got_n !== 5) begin errors++; $display("FAIL step0_count got %0d want 5", got_n); end
    for (int i = 0; i < got_n; i++) begin
      checks++; if (got_div[i] !== 6 || got_duty[i] !== 0) begin
        errors++; $display("FAIL step0_val[%0d] got %0d/%0d want 6/0", i, got_div[i], got_duty[i]); end
      if (i > 0) begin
        checks++; if (got_len[i] !== 6) begin
          errors++; $display("FAIL step0_len[%0d] got %0d want 6", i, got_len[i]); end
      end
    end
  endtask

  task automatic test_enable_drop;
    start_sweep(10, 20, 5, 2, 16'h8000, 1'b0);
    repeat (6) @(negedge clk);
    checks++; if (divider !== 32'd10 || period_tick !== 1'b0) begin
      errors++; $display("FAIL drop_pre got %0d %b want 10 0", divider, period_tick); end
    enable = 1'b0;
    @(negedge clk);
    checks++; if (divider !== 32'd0 || duty !== 32'd0) begin
      errors++; $display("FAIL drop_zero got %0d/%0d want 0/0", divider, duty); end
    enable = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (divider !== 32'd0) begin errors++; $display("FAIL drop_load got %0d want 0", divider); end
    @(negedge clk);
    checks++; if (divider !== 32'd10 || duty !== 32'd5) begin
      errors++; $display("FAIL drop_restart got %0d/%0d want 10/5", divider, duty); end
  endtask

  task automatic test_reset_mid;
    start_sweep(20, 10, 10, 1, 16'h8000, 1'b1);
    repeat (12) @(negedge clk);
    #2 reset = 1'b0; enable = 1'b0;
    #1;
    checks++; if (divider !== 32'd0 || duty !== 32'd0 || period_tick !== 1'b0 || sweep_done !== 1'b0) begin
      errors++; $display("FAIL async_reset got %0d/%0d %b%b want 0/0 00", divider, duty, period_tick, sweep_done); end
    @(negedge clk); reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; loop_mode = 1'b0;
    start_div = '0; stop_div = '0; step = '0; dwell = '0; duty_frac = '0;
    test_reset;
    test_up;
    test_saturation;
    test_down_loop;
    test_loop_wrap;
    test_degenerate;
    test_step0;
    test_enable_drop;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
